// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate sign/zero/upper/branch extension into a 2-entry output FIFO
// The head entry is mirrored in a register so OUT_DATA keeps its last value when the buffer empties.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic [1:0]       IN_MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic [1:0]       COUNT
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic [OUT_W-1:0] head_q, head_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_upper;
  logic [OUT_W-1:0] ext_branch;
  logic [OUT_W-1:0] ext_word;
  logic             push;
  logic             pop;

  always_comb begin
    ext_sign   = {{PAD_W{IN_DATA[IN_W-1]}}, IN_DATA};
    ext_zero   = {{PAD_W{1'b0}}, IN_DATA};
    ext_upper  = {IN_DATA, {PAD_W{1'b0}}};
    ext_branch = {ext_sign[OUT_W-3:0], 2'b00};
    case (IN_MODE)
      2'b00:   ext_word = ext_sign;
      2'b01:   ext_word = ext_zero;
      2'b10:   ext_word = ext_upper;
      default: ext_word = ext_branch;
    endcase
  end

  assign IN_READY  = (count_q != 2'd2);
  assign OUT_VALID = (count_q != 2'd0);
  assign OUT_DATA  = head_q;
  assign COUNT     = count_q;

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_VALID && OUT_READY;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push) begin
      mem_d[wr_ptr_q] = ext_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Head follows whichever entry becomes oldest; an emptying pop leaves it holding.
    if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
      head_d = ext_word;
    end else if (pop && count_q == 2'd2) begin
      head_d = mem_q[~rd_ptr_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe (default and 8/16 widths)
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic [1:0]  in_mode8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] out_data8;
  logic [1:0]  count8;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  imm_extend_pipe u_dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_MODE(in_mode),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .COUNT(count)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid8), .IN_READY(in_ready8), .IN_DATA(in_data8), .IN_MODE(in_mode8),
    .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .OUT_DATA(out_data8), .COUNT(count8)
  );

  function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = d[15] ? (32'hFFFF0000 | 32'(d)) : 32'(d);
    case (m)
      2'b00:   return s;
      2'b01:   return 32'(d);
      2'b10:   return 32'(d) * 32'd65536;
      default: return s * 32'd4;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'hABCD; in_mode = 2'b00; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = 8'h00; in_mode8 = 2'b00; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd0)      begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== 32'h0)  begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
  endtask

  task automatic test_modes;
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF8004; exp_tab[1] = 32'h00008004;
    exp_tab[2] = 32'h80040000; exp_tab[3] = 32'hFFFE0010;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 16'h8004, 2'(m), 1'b1);
      drive(1'b0, 16'h0000, 2'b00, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got %b exp 1", m, out_valid); end
      checks++; if (out_data !== exp_tab[m]) begin errors++; $display("FAIL mode%0d_data got %h exp %h", m, out_data, exp_tab[m]); end
      checks++; if (out_data !== model_ext(16'h8004, 2'(m))) begin errors++; $display("FAIL mode%0d_model got %h exp %h", m, out_data, model_ext(16'h8004, 2'(m))); end
    end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL modes_drain_count got %0d exp 0", count); end
    checks++; if (out_data !== 32'hFFFE0010) begin errors++; $display("FAIL empty_hold got %h exp fffe0010", out_data); end
  endtask

  task automatic test_backpressure;
    drive(1'b1, 16'h0001, 2'b00, 1'b0);
    drive(1'b1, 16'h0002, 2'b01, 1'b0);
    drive(1'b1, 16'h0003, 2'b00, 1'b0);
    checks++; if (count !== 2'd2)    begin errors++; $display("FAIL bp_count got %0d exp 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_head got %h exp 1", out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    checks++; if (count !== 2'd2)    begin errors++; $display("FAIL bp_full_hold got %0d exp 2", count); end
    checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_stable got %h exp 1", out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    checks++; if (count !== 2'd1)    begin errors++; $display("FAIL bp_pop1_count got %0d exp 1", count); end
    checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL bp_pop1_data got %h exp 2", out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    checks++; if (count !== 2'd0)    begin errors++; $display("FAIL bp_pop2_count got %0d exp 0", count); end
  endtask

  task automatic test_streaming;
    int outs = 0;
    sb_q.delete();
    for (int i = 0; i < 11; i++) begin
      drive(i < 8, 16'(i), 2'b01, 1'b1);
      if (i >= 1 && i <= 8) begin
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL stream_count cyc%0d got %0d exp 1", i, count); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL stream_spurious got %h exp none", out_data); end
        else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL stream_data got %h exp %h", out_data, e); end
        end
        outs++;
      end
      if (in_valid && in_ready) sb_q.push_back(model_ext(in_data, in_mode));
    end
    checks++; if (outs != 8) begin errors++; $display("FAIL stream_outs got %0d exp 8", outs); end
  endtask

  task automatic test_simultaneous;
    drive(1'b1, 16'h1234, 2'b01, 1'b0);
    drive(1'b1, 16'hFFFF, 2'b00, 1'b1);
    checks++; if (out_data !== 32'h00001234) begin errors++; $display("FAIL simul_head got %h exp 00001234", out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL simul_count got %0d exp 1", count); end
    checks++; if (out_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL simul_data got %h exp ffffffff", out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back;
    int budget = 0;
    int pushed = 0;
    int popped = 0;
    sb_q.delete();
    while ((pushed < 60 || sb_q.size() != 0) && budget < 2000) begin
      drive((pushed < 60) && ($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), $urandom_range(0, 2) != 0);
      budget++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_spurious got %h exp none", out_data); end
        else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          if (out_data !== e) begin errors++; $display("FAIL b2b_data got %h exp %h", out_data, e); end
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model_ext(in_data, in_mode));
        pushed++;
      end
      checks++; if (count !== 2'(sb_q.size() > 2 ? 3 : sb_q.size()) && !(out_valid && out_ready) && !(in_valid && in_ready))
        begin errors++; $display("FAIL b2b_count got %0d exp %0d", count, sb_q.size()); end
    end
    checks++; if (budget >= 2000 || popped != 60) begin errors++; $display("FAIL b2b_done got %0d exp 60", popped); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 16'h0011, 2'b01, 1'b0);
    drive(1'b1, 16'h0022, 2'b01, 1'b0);
    drive(1'b1, 16'h0033, 2'b01, 1'b1);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL rmid_full got %0d exp 2", count); end
    rst = 1'b1;
    drive(1'b1, 16'h0005, 2'b01, 1'b1);
    rst = 1'b0;
    checks++; if (count !== 2'd0)     begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", out_data); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
    checks++; if (count !== 2'd1 || out_data !== 32'h5) begin errors++; $display("FAIL rmid_first_push got %0d/%h exp 1/00000005", count, out_data); end
    drive(1'b0, 16'h0000, 2'b00, 1'b1);
    drive(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic test_param;
    logic [15:0] exp8 [3];
    logic [1:0]  mode8 [3];
    exp8[0] = 16'hFF80; exp8[1] = 16'h8000; exp8[2] = 16'hFE00;
    mode8[0] = 2'b00;   mode8[1] = 2'b10;   mode8[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid8 = 1'b1; in_data8 = 8'h80; in_mode8 = mode8[k]; out_ready8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      checks++; if (out_valid8 !== 1'b1 || out_data8 !== exp8[k])
        begin errors++; $display("FAIL param_mode%0d got %b/%h exp 1/%h", mode8[k], out_valid8, out_data8, exp8[k]); end
    end
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter: IN_W, default 16, immediate field width in bits; legal range 2..OUT_W-2.
REQ-002 Parameter: OUT_W, default 32, extended datapath width in bits.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, synchronous and active-high.
REQ-005 Port: IN_VALID  input  1  producer offers an immediate this cycle.
REQ-006 Port: IN_READY  output  1  block can accept an immediate this cycle.
REQ-007 Port: IN_DATA  input  IN_W  raw immediate field.
REQ-008 Port: IN_MODE  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
REQ-009 Port: OUT_VALID  output  1  OUT_DATA holds a valid extended word.
REQ-010 Port: OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
REQ-011 Port: OUT_DATA  output  OUT_W  extended result, head of buffer.
REQ-012 Port: COUNT  output  2  buffer occupancy, 0..2.

Function
REQ-013 Input transfer ("push") SHALL occur on a rising edge where IN_VALID=1 and IN_READY=1; output transfer ("pop") where OUT_VALID=1 and OUT_READY=1.
REQ-014 Extension SHALL be computed combinationally from IN_DATA/IN_MODE at push time; the buffer stores the OUT_W-bit result, not the raw field.
REQ-015 Mode 00 (sign): OUT[IN_W-1:0]=IN_DATA; OUT[OUT_W-1:IN_W]=replicated IN_DATA[IN_W-1].
REQ-016 Mode 01 (zero): OUT[IN_W-1:0]=IN_DATA; upper bits 0.
REQ-017 Mode 10 (upper): OUT = IN_DATA shifted left by (OUT_W-IN_W), low (OUT_W-IN_W) bits 0, i.e. IN_DATA occupies the top IN_W bits.
REQ-018 Mode 11 (branch): OUT = (mode-00 result) shifted left by 2, truncated to OUT_W; bits [1:0]=0.
REQ-019 Buffer SHALL be a 2-entry in-order FIFO; OUT_DATA always shows the oldest entry; data SHALL pop in push order.
REQ-020 IN_READY SHALL equal (COUNT!=2), derived from registered state only; it SHALL NOT depend combinationally on OUT_READY or IN_VALID.
REQ-021 OUT_VALID SHALL equal (COUNT!=0), registered-state derived.
REQ-022 Latency: word pushed at edge k with COUNT=0 SHALL appear with OUT_VALID=1 in the cycle after edge k (1 cycle); no combinational IN_DATA->OUT_DATA path.
REQ-023 Throughput: with OUT_READY held 1 and IN_VALID held 1, one push and one pop SHALL occur every cycle after the first.
REQ-024 COUNT update: push only +1; pop only -1; push and pop same edge unchanged (legal at COUNT=1 only; at COUNT=0 no pop, at COUNT=2 no push).
REQ-025 Full (COUNT=2): IN_VALID ignored, IN_READY=0, stored entries unchanged until a pop.
REQ-026 Empty (COUNT=0): OUT_READY ignored; OUT_DATA SHALL hold last value (0 after reset), undefined content not permitted.
REQ-027 While OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL remain stable.
REQ-028 Internal read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-029 RST=1 at a rising edge SHALL set COUNT=0, pointers=0, OUT_VALID=0, IN_READY=1, OUT_DATA=0, discarding any buffered entries, regardless of IN_VALID/OUT_READY that cycle.
REQ-030 Reset asserted mid-stream SHALL take priority over a simultaneous push or pop; first push accepted on the first edge with RST=0.

Verification
REQ-031 Modes, defaults, COUNT=0, OUT_READY=1: push 16'h8004 with modes 00,01,10,11 -> OUT_DATA 32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, each 1 cycle after push.
REQ-032 Backpressure: OUT_READY=0, push 16'h0001 (m00), 16'h0002 (m01), offer 16'h0003 -> COUNT=2, IN_READY=0, third not accepted, OUT_DATA=32'h00000001 stable; raise OUT_READY -> pops 1 then 2, COUNT 2->1->0.
REQ-033 Streaming: IN_VALID=1 and OUT_READY=1 for 8 cycles, data 0..7 mode 01 -> 8 outputs 0..7 in order, COUNT stays 1 after first edge.
REQ-034 Simultaneous at COUNT=1: push 16'hFFFF (m00) while popping -> COUNT stays 1, next OUT_DATA=32'hFFFFFFFF.
REQ-035 Reset mid-operation: COUNT=2, assert RST with IN_VALID=1, OUT_READY=1 -> next cycle COUNT=0, OUT_VALID=0, OUT_DATA=0, IN_READY=1.
REQ-036 Parameter sweep: IN_W=8, OUT_W=16, push 8'h80 modes 00/10/11 -> 16'hFF80, 16'h8000, 16'hFE00.
